ux607_reg_responder: RTL and testbench

Register-bank responder for the peripheral request channel. It consumes single-beat read/write requests (read, index, data, mask, extra) from the upstream request queue. It applies them to a bank of byte-maskable 32-bit registers and returns one response per request through an internal response FIFO. It sits on the slave side of the peripheral bus bridge, opposite the request-queue producer.

---
 rtl/ux607_reg_responder.sv | 106 ++++++++++
 tb/tb_ux607_reg_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_reg_responder.sv
// rtl/ux607_reg_responder.sv - byte-maskable register bank answering single-beat requests
// through an in-order response FIFO.
module ux607_reg_responder #(
  parameter int NREGS      = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic                          io_req_ready,
  input  logic                          io_req_valid,
  input  logic                          io_req_bits_read,
  input  logic [9:0]                    io_req_bits_index,
  input  logic [31:0]                   io_req_bits_data,
  input  logic [3:0]                    io_req_bits_mask,
  input  logic [9:0]                    io_req_bits_extra,
  input  logic                          io_resp_ready,
  output logic                          io_resp_valid,
  output logic                          io_resp_bits_read,
  output logic [31:0]                   io_resp_bits_data,
  output logic [9:0]                    io_resp_bits_extra,
  output logic                          io_resp_bits_err,
  output logic [NREGS*32-1:0]           io_regs,
  output logic [$clog2(RESP_DEPTH):0]   io_count
);

  localparam int          IW      = $clog2(NREGS);
  localparam int          PW      = $clog2(RESP_DEPTH);
  localparam logic [9:0]  NREGS_W = 10'(NREGS);

  logic [31:0]   r_regs [NREGS];
  logic [PW-1:0] r_enq_ptr;
  logic [PW-1:0] r_deq_ptr;
  logic          r_maybe_full;

  logic          r_q_read  [RESP_DEPTH];
  logic [31:0]   r_q_data  [RESP_DEPTH];
  logic [9:0]    r_q_extra [RESP_DEPTH];
  logic          r_q_err   [RESP_DEPTH];

  logic          w_ptr_match;
  logic          w_full;
  logic          w_empty;
  logic          w_do_req;
  logic          w_do_deq;
  logic          w_in_range;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_resp_data;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_full      = w_ptr_match & r_maybe_full;
  assign w_empty     = w_ptr_match & ~r_maybe_full;

  assign io_req_ready  = ~w_full;
  assign io_resp_valid = ~w_empty;
  assign w_do_req      = io_req_valid & io_req_ready;
  assign w_do_deq      = io_resp_valid & io_resp_ready;

  assign w_in_range  = (io_req_bits_index < NREGS_W);
  assign w_idx       = io_req_bits_index[IW-1:0];
  // Read data is sampled before the accept edge, so a same-edge write can never leak in.
  assign w_resp_data = (io_req_bits_read & w_in_range) ? r_regs[w_idx] : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= 32'd0;
    end else if (w_do_req & ~io_req_bits_read & w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (io_req_bits_mask[b]) r_regs[w_idx][8*b +: 8] <= io_req_bits_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_req) r_enq_ptr <= r_enq_ptr + 1'b1;
      if (w_do_deq) r_deq_ptr <= r_deq_ptr + 1'b1;
      if (w_do_req != w_do_deq) r_maybe_full <= w_do_req;
    end
  end

  // Payload storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (w_do_req) begin
      r_q_read[r_enq_ptr]  <= io_req_bits_read;
      r_q_data[r_enq_ptr]  <= w_resp_data;
      r_q_extra[r_enq_ptr] <= io_req_bits_extra;
      r_q_err[r_enq_ptr]   <= ~w_in_range;
    end
  end

  assign io_resp_bits_read  = r_q_read[r_deq_ptr];
  assign io_resp_bits_data  = r_q_data[r_deq_ptr];
  assign io_resp_bits_extra = r_q_extra[r_deq_ptr];
  assign io_resp_bits_err   = r_q_err[r_deq_ptr];

  assign io_count = {w_full, r_enq_ptr - r_deq_ptr};

  for (genvar k = 0; k < NREGS; k++) begin : g_regs_flat
    assign io_regs[32*k +: 32] = r_regs[k];
  end

endmodule

// File: tb/tb_ux607_reg_responder.sv
// tb/tb_ux607_reg_responder.sv - directed table, corner sequences and randomized
// traffic against a queue-based reference model.
module tb_ux607_reg_responder;

  localparam int NREGS = 16;
  localparam int DEPTH = 2;

  logic                 clock;
  logic                 reset;
  logic                 req_ready;
  logic                 req_valid;
  logic                 req_read;
  logic [9:0]           req_index;
  logic [31:0]          req_data;
  logic [3:0]           req_mask;
  logic [9:0]           req_extra;
  logic                 resp_ready;
  logic                 resp_valid;
  logic                 resp_read;
  logic [31:0]          resp_data;
  logic [9:0]           resp_extra;
  logic                 resp_err;
  logic [NREGS*32-1:0]  regs_flat;
  logic [1:0]           count;

  ux607_reg_responder #(.NREGS(NREGS), .RESP_DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_req_ready       (req_ready),
    .io_req_valid       (req_valid),
    .io_req_bits_read   (req_read),
    .io_req_bits_index  (req_index),
    .io_req_bits_data   (req_data),
    .io_req_bits_mask   (req_mask),
    .io_req_bits_extra  (req_extra),
    .io_resp_ready      (resp_ready),
    .io_resp_valid      (resp_valid),
    .io_resp_bits_read  (resp_read),
    .io_resp_bits_data  (resp_data),
    .io_resp_bits_extra (resp_extra),
    .io_resp_bits_err   (resp_err),
    .io_regs            (regs_flat),
    .io_count           (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic        rd;
    logic [9:0]  idx;
    logic [31:0] d;
    logic [3:0]  m;
    logic [9:0]  ex;
    logic        rr;
    logic        e_ready;
    logic        e_valid;
    logic [1:0]  e_count;
    logic        e_rd;
    logic [31:0] e_data;
    logic [9:0]  e_ex;
    logic        e_err;
  } row_t;

  function automatic row_t mk(input logic v, rd, input logic [9:0] idx, input logic [31:0] d,
                              input logic [3:0] m, input logic [9:0] ex, input logic rr,
                              input logic e_ready, e_valid, input logic [1:0] e_count,
                              input logic e_rd, input logic [31:0] e_data,
                              input logic [9:0] e_ex, input logic e_err);
    row_t r;
    r.v = v; r.rd = rd; r.idx = idx; r.d = d; r.m = m; r.ex = ex; r.rr = rr;
    r.e_ready = e_ready; r.e_valid = e_valid; r.e_count = e_count;
    r.e_rd = e_rd; r.e_data = e_data; r.e_ex = e_ex; r.e_err = e_err;
    return r;
  endfunction

  task automatic drive(input logic v, rd, input logic [9:0] idx, input logic [31:0] d,
                       input logic [3:0] m, input logic [9:0] ex, input logic rr);
    req_valid = v; req_read = rd; req_index = idx; req_data = d;
    req_mask = m; req_extra = ex; resp_ready = rr;
  endtask

  // Reference model: a plain array of registers and a queue of pending responses.
  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic [9:0]  ex;
    logic        err;
  } resp_t;

  logic [31:0] mregs [NREGS];
  resp_t       mq [$];

  task automatic model_clear();
    for (int k = 0; k < NREGS; k++) mregs[k] = 32'd0;
    mq.delete();
  endtask

  task automatic mstep(input logic v, rd, input logic [9:0] idx, input logic [31:0] d,
                       input logic [3:0] m, input logic [9:0] ex, input logic rr,
                       output logic accepted);
    resp_t r;
    logic  deq;
    @(negedge clock);
    drive(v, rd, idx, d, m, ex, rr);
    #1;
    chk("m_req_ready", req_ready, (mq.size() != DEPTH));
    chk("m_resp_valid", resp_valid, (mq.size() != 0));
    chk("m_count", count, mq.size());
    if (mq.size() != 0) begin
      chk("m_resp_read", resp_read, mq[0].rd);
      chk("m_resp_data", resp_data, mq[0].data);
      chk("m_resp_extra", resp_extra, mq[0].ex);
      chk("m_resp_err", resp_err, mq[0].err);
    end
    for (int k = 0; k < NREGS; k++) chk($sformatf("m_reg%0d", k), regs_flat[32*k +: 32], mregs[k]);
    accepted = v && (mq.size() != DEPTH);
    deq      = rr && (mq.size() != 0);
    @(posedge clock);
    if (deq) void'(mq.pop_front());
    if (accepted) begin
      r.rd   = rd;
      r.ex   = ex;
      r.err  = (idx >= NREGS);
      r.data = (!r.err && rd) ? mregs[idx] : 32'd0;
      mq.push_back(r);
      if (!rd && !r.err)
        for (int b = 0; b < 4; b++) if (m[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_regs_zero", (regs_flat == '0), 1'b1);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  row_t tbl [13];
  logic acc;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 10'd0, 1'b0);
    model_clear();

    tbl[0]  = mk(0, 0, 10'd0,  32'h0,        4'h0, 10'h000, 1, 1, 0, 0, 0, 32'h0,        10'h000, 0);
    tbl[1]  = mk(1, 0, 10'd3,  32'hA5A51234, 4'h5, 10'h011, 1, 1, 0, 0, 0, 32'h0,        10'h000, 0);
    tbl[2]  = mk(1, 1, 10'd3,  32'h0,        4'h0, 10'h022, 1, 1, 1, 1, 0, 32'h0,        10'h011, 0);
    tbl[3]  = mk(1, 1, 10'd16, 32'h0,        4'h0, 10'h2AB, 1, 1, 1, 1, 1, 32'h00A50034, 10'h022, 0);
    tbl[4]  = mk(0, 0, 10'd0,  32'h0,        4'h0, 10'h000, 1, 1, 1, 1, 1, 32'h0,        10'h2AB, 1);
    tbl[5]  = mk(0, 0, 10'd0,  32'h0,        4'h0, 10'h000, 0, 1, 0, 0, 0, 32'h0,        10'h000, 0);
    tbl[6]  = mk(1, 0, 10'd1,  32'h11111111, 4'hF, 10'h101, 0, 1, 0, 0, 0, 32'h0,        10'h000, 0);
    tbl[7]  = mk(1, 0, 10'd2,  32'h22222222, 4'hF, 10'h102, 0, 1, 1, 1, 0, 32'h0,        10'h101, 0);
    tbl[8]  = mk(1, 0, 10'd4,  32'h44444444, 4'hF, 10'h103, 0, 0, 1, 2, 0, 32'h0,        10'h101, 0);
    tbl[9]  = mk(1, 0, 10'd4,  32'h44444444, 4'hF, 10'h103, 1, 0, 1, 2, 0, 32'h0,        10'h101, 0);
    tbl[10] = mk(1, 0, 10'd4,  32'h44444444, 4'hF, 10'h103, 1, 1, 1, 1, 0, 32'h0,        10'h102, 0);
    tbl[11] = mk(0, 0, 10'd0,  32'h0,        4'h0, 10'h000, 1, 1, 1, 1, 0, 32'h0,        10'h103, 0);
    tbl[12] = mk(0, 0, 10'd0,  32'h0,        4'h0, 10'h000, 1, 1, 0, 0, 0, 32'h0,        10'h000, 0);

    repeat (2) @(negedge clock);
    #1;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_count", count, 2'd0);
    chk("reset_regs_zero", (regs_flat == '0), 1'b1);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      drive(tbl[i].v, tbl[i].rd, tbl[i].idx, tbl[i].d, tbl[i].m, tbl[i].ex, tbl[i].rr);
      #1;
      chk($sformatf("row%0d_req_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("row%0d_resp_valid", i), resp_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_count", i), count, tbl[i].e_count);
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_resp_read", i), resp_read, tbl[i].e_rd);
        chk($sformatf("row%0d_resp_data", i), resp_data, tbl[i].e_data);
        chk($sformatf("row%0d_resp_extra", i), resp_extra, tbl[i].e_ex);
        chk($sformatf("row%0d_resp_err", i), resp_err, tbl[i].e_err);
      end
      if (i == 5) chk("err_read_no_reg_change", (regs_flat[32*16-1:32*4] == '0) && (regs_flat[95:0] == '0), 1'b1);
    end
    chk("tbl_reg1", regs_flat[32*1 +: 32], 32'h11111111);
    chk("tbl_reg2", regs_flat[32*2 +: 32], 32'h22222222);
    chk("tbl_reg3", regs_flat[32*3 +: 32], 32'h00A50034);
    chk("tbl_reg4", regs_flat[32*4 +: 32], 32'h44444444);

    do_reset();

    // Back-to-back: 8 writes then 8 reads with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      mstep(1'b1, (i >= 8), 10'(i % 8), 32'hC0DE_0000 + 32'(i * 32'h0101_0011), 4'hF,
            10'(i + 10'h40), 1'b1, acc);
      chk("b2b_accept", acc, 1'b1);
      chk("b2b_count_le1", (count <= 2'd1), 1'b1);
    end
    mstep(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 10'd0, 1'b1, acc);

    // Randomized traffic with occasional out-of-range indices and back-pressure.
    for (int i = 0; i < 400; i++) begin
      mstep(($urandom_range(0, 3) != 0), 1'($urandom), 10'($urandom_range(0, 19)), $urandom,
            4'($urandom), 10'($urandom), ($urandom_range(0, 2) != 0), acc);
    end

    // Reset with two queued responses and nonzero registers.
    mstep(1'b1, 1'b0, 10'd5, 32'hDEADBEEF, 4'hF, 10'h3FF, 1'b0, acc);
    mstep(1'b1, 1'b0, 10'd6, 32'h12345678, 4'hF, 10'h3FE, 1'b0, acc);
    mstep(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 10'd0, 1'b0, acc);
    chk("pre_rst_count", count, 2'd2);
    do_reset();
    mstep(1'b0, 1'b0, 10'd0, 32'd0, 4'h0, 10'd0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
